// File: rtl/adder_axi_pkg.sv
// Shared types and constants for the adder peripheral AXI4-Lite master.
package adder_axi_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_R0   = 4'd1,
    S_WR_R1   = 4'd2,
    S_WR_CTRL = 4'd3,
    S_POLL_AR = 4'd4,
    S_POLL_R  = 4'd5,
    S_RES_AR  = 4'd6,
    S_RES_R   = 4'd7,
    S_RSP     = 4'd8
  } state_e;

  localparam logic [3:0] REG_R0   = 4'h0;
  localparam logic [3:0] REG_R1   = 4'h4;
  localparam logic [3:0] REG_CTRL = 4'h8;
  localparam logic [3:0] REG_RES  = 4'hC;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_OP_BIT    = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic resp_ok(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/adder_axi_master_xfer.sv
// One AXI4-Lite read or write at a time. AW and W are tracked independently,
// BREADY rises once both have been accepted; RREADY rises once AR is accepted.
// done_o/resp_o/rdata_o are combinational views of the B or R handshake so the
// caller can launch the next transfer in the same cycle.
module axi_lite_single_xfer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic              ar_hs_o,
  output logic [1:0]        resp_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  logic              awvalid_q, wvalid_q, bready_q, wr_act_q;
  logic              arvalid_q, rready_q;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_left, w_left;

  assign aw_hs   = awvalid_q & awready_i;
  assign w_hs    = wvalid_q & wready_i;
  assign b_hs    = bready_q & bvalid_i;
  assign ar_hs   = arvalid_q & arready_i;
  assign r_hs    = rready_q & rvalid_i;
  assign aw_left = awvalid_q & ~awready_i;
  assign w_left  = wvalid_q & ~wready_i;

  // Write channel: hold AW/W until each READY, then wait for B. A new start
  // is written last so it wins over the completion of the previous write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs) wvalid_q <= 1'b0;
      if (wr_act_q && !bready_q && !aw_left && !w_left) bready_q <= 1'b1;
      if (b_hs) begin
        bready_q <= 1'b0;
        wr_act_q <= 1'b0;
      end
      if (start_i && write_i) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        wr_act_q  <= 1'b1;
        awaddr_q  <= addr_i;
        wdata_q   <= wdata_i;
      end
    end
  end

  // Read channel: hold AR until ARREADY, then accept exactly one R beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
    end else begin
      if (ar_hs) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (r_hs) rready_q <= 1'b0;
      if (start_i && !write_i) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_i;
      end
    end
  end

  assign done_o    = b_hs | r_hs;
  assign ar_hs_o   = ar_hs;
  assign resp_o    = b_hs ? bresp_i : rresp_i;
  assign rdata_o   = rdata_i;
  assign awaddr_o  = awaddr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;
  assign araddr_o  = araddr_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

endmodule

// File: rtl/adder_axi_master.sv
// Command-driven AXI4-Lite sequencer for the adder peripheral: write A, B and
// CTRL, poll CTRL.start until clear, read RES, return it on the response port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready for a command; no bus activity
// S_WR_R0   | writing operand A
// S_WR_R1   | writing operand B
// S_WR_CTRL | writing {op, start=1}
// S_POLL_AR | status read address phase
// S_POLL_R  | status read data phase; decide done / retry / timeout
// S_RES_AR  | result read address phase
// S_RES_R   | result read data phase
// S_RSP     | response held until accepted
module adder_axi_master
  import adder_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       POLL_MAX  = 1024,
  parameter logic [ADDR_W-1:0] ADDR_R0   = ADDR_W'(REG_R0),
  parameter logic [ADDR_W-1:0] ADDR_R1   = ADDR_W'(REG_R1),
  parameter logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(REG_CTRL),
  parameter logic [ADDR_W-1:0] ADDR_RES  = ADDR_W'(REG_RES)
) (
  input  logic                ACLK,
  input  logic                ARSTn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [DATA_W-1:0]   i_cmd_a,
  input  logic [DATA_W-1:0]   i_cmd_b,
  input  logic                i_cmd_op,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic [1:0]          o_rsp_err,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int unsigned       POLL_W   = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              op_q, op_d;
  logic [POLL_W-1:0] poll_q, poll_d, poll_inc;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_ready_q, rsp_valid_q;
  logic [DATA_W-1:0] ctrl_word;

  logic              x_start, x_write, x_done, x_ar_hs;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata, x_rdata;
  logic [1:0]        x_resp;

  axi_lite_single_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk_i     (ACLK),
    .rst_ni    (ARSTn),
    .start_i   (x_start),
    .write_i   (x_write),
    .addr_i    (x_addr),
    .wdata_i   (x_wdata),
    .done_o    (x_done),
    .ar_hs_o   (x_ar_hs),
    .resp_o    (x_resp),
    .rdata_o   (x_rdata),
    .awaddr_o  (M_AXI_AWADDR),
    .awvalid_o (M_AXI_AWVALID),
    .awready_i (M_AXI_AWREADY),
    .wdata_o   (M_AXI_WDATA),
    .wvalid_o  (M_AXI_WVALID),
    .wready_i  (M_AXI_WREADY),
    .bresp_i   (M_AXI_BRESP),
    .bvalid_i  (M_AXI_BVALID),
    .bready_o  (M_AXI_BREADY),
    .araddr_o  (M_AXI_ARADDR),
    .arvalid_o (M_AXI_ARVALID),
    .arready_i (M_AXI_ARREADY),
    .rdata_i   (M_AXI_RDATA),
    .rresp_i   (M_AXI_RRESP),
    .rvalid_i  (M_AXI_RVALID),
    .rready_o  (M_AXI_RREADY)
  );

  // Next-state and transfer launch; a transfer starts on the same edge that
  // enters its state so back-to-back accesses have no idle cycle between them.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    poll_d     = poll_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    x_start    = 1'b0;
    x_write    = 1'b0;
    x_addr     = ADDR_R0;
    x_wdata    = '0;
    poll_inc   = poll_q + 1'b1;
    ctrl_word  = '0;
    ctrl_word[CTRL_START_BIT] = 1'b1;
    ctrl_word[CTRL_OP_BIT]    = op_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          a_d        = i_cmd_a;
          b_d        = i_cmd_b;
          op_d       = i_cmd_op;
          err_d      = ERR_NONE;
          rsp_data_d = '0;
          poll_d     = '0;
          x_start    = 1'b1;
          x_write    = 1'b1;
          x_addr     = ADDR_R0;
          x_wdata    = i_cmd_a;
          state_d    = S_WR_R0;
        end
      end
      S_WR_R0: begin
        if (x_done) begin
          if (!resp_ok(x_resp)) begin
            err_d   = ERR_BUS;
            state_d = S_RSP;
          end else begin
            x_start = 1'b1;
            x_write = 1'b1;
            x_addr  = ADDR_R1;
            x_wdata = b_q;
            state_d = S_WR_R1;
          end
        end
      end
      S_WR_R1: begin
        if (x_done) begin
          if (!resp_ok(x_resp)) begin
            err_d   = ERR_BUS;
            state_d = S_RSP;
          end else begin
            x_start = 1'b1;
            x_write = 1'b1;
            x_addr  = ADDR_CTRL;
            x_wdata = ctrl_word;
            state_d = S_WR_CTRL;
          end
        end
      end
      S_WR_CTRL: begin
        if (x_done) begin
          if (!resp_ok(x_resp)) begin
            err_d   = ERR_BUS;
            state_d = S_RSP;
          end else begin
            x_start = 1'b1;
            x_addr  = ADDR_CTRL;
            state_d = S_POLL_AR;
          end
        end
      end
      S_POLL_AR: begin
        if (x_ar_hs) state_d = S_POLL_R;
      end
      S_POLL_R: begin
        if (x_done) begin
          if (!resp_ok(x_resp)) begin
            err_d   = ERR_BUS;
            state_d = S_RSP;
          end else if (!x_rdata[CTRL_START_BIT]) begin
            x_start = 1'b1;
            x_addr  = ADDR_RES;
            state_d = S_RES_AR;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == POLL_LIM) begin
              err_d   = ERR_TIMEOUT;
              state_d = S_RSP;
            end else begin
              x_start = 1'b1;
              x_addr  = ADDR_CTRL;
              state_d = S_POLL_AR;
            end
          end
        end
      end
      S_RES_AR: begin
        if (x_ar_hs) state_d = S_RES_R;
      end
      S_RES_R: begin
        if (x_done) begin
          rsp_data_d = x_rdata;
          if (!resp_ok(x_resp)) err_d = ERR_BUS;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          poll_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered handshake outputs, derived from the next state.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      poll_q      <= '0;
      err_q       <= ERR_NONE;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      poll_q      <= poll_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RSP);
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = err_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

endmodule
